// File: rtl/vector_dot_product.sv
// ---------------------------------------------------------------------------
// vector_dot_product
//
// Fixed-point dot-product stage. A vector offered with vector_ready is
// snapshotted together with the coefficient register. The snapshot is then
// multiplied element by element, one element per cycle. The products are
// accumulated at full width. The sum is floor-shifted by FRAC_BITS, saturated
// to ELEMENT_WIDTH and presented with a one-cycle result_valid. A one-entry
// pending buffer accepts one extra vector while a computation is running.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   enabled           : clock enable; low freezes all state and ignores inputs
//   vector, vector_ready : input vector and its single-cycle qualifier
//   coeff_in, coeff_load : coefficient vector and its load strobe
//   result, result_valid : saturated dot product and its one-cycle pulse
//   busy              : FSM is not IDLE
//   pending_full      : pending buffer holds a vector
//   overflow, dropped : sticky saturation / discarded-vector flags
//   result_count      : number of results produced (wraps)
// ---------------------------------------------------------------------------
module vector_dot_product #(
    parameter int ELEMENT_WIDTH    = 24,
    parameter int FRAC_BITS        = 8,
    parameter int VECTOR_DIMENSION = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enabled,
    input  logic signed [ELEMENT_WIDTH-1:0] vector   [0:VECTOR_DIMENSION-1],
    input  logic                            vector_ready,
    input  logic signed [ELEMENT_WIDTH-1:0] coeff_in [0:VECTOR_DIMENSION-1],
    input  logic                            coeff_load,
    output logic signed [ELEMENT_WIDTH-1:0] result,
    output logic                            result_valid,
    output logic                            busy,
    output logic                            pending_full,
    output logic                            overflow,
    output logic                            dropped,
    output logic        [ELEMENT_WIDTH-1:0] result_count
);

    localparam int W     = ELEMENT_WIDTH;
    localparam int D     = VECTOR_DIMENSION;
    localparam int ACC_W = 2 * W + $clog2(D) + 1;
    localparam int IDX_W = (D > 1) ? $clog2(D) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(D - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]     COUNT_ONE = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Floor-shift the accumulator and clamp it into W bits.
    // Returns {saturated_flag, value}. The shifted value fits in W bits
    // exactly when all bits from the MSB down to bit W-1 agree.
    function automatic logic [W:0] shift_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        sh = a >>> FRAC_BITS;
        if ((&sh[ACC_W-1:W-1]) || (~|sh[ACC_W-1:W-1])) begin
            return {1'b0, sh[W-1:0]};
        end else if (sh[ACC_W-1]) begin
            return {1'b1, 1'b1, {(W-1){1'b0}}};
        end else begin
            return {1'b1, 1'b0, {(W-1){1'b1}}};
        end
    endfunction

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [W-1:0]     work_v_q [0:D-1];
    logic signed [W-1:0]     work_v_d [0:D-1];
    logic signed [W-1:0]     work_c_q [0:D-1];
    logic signed [W-1:0]     work_c_d [0:D-1];
    logic signed [W-1:0]     pend_v_q [0:D-1];
    logic signed [W-1:0]     pend_v_d [0:D-1];
    logic signed [W-1:0]     coeff_q  [0:D-1];
    logic signed [W-1:0]     coeff_d  [0:D-1];
    logic                    pend_full_q, pend_full_d;
    logic signed [W-1:0]     result_q, result_d;
    logic                    result_valid_q, result_valid_d;
    logic                    busy_q, busy_d;
    logic                    overflow_q, overflow_d;
    logic                    dropped_q, dropped_d;
    logic [W-1:0]            count_q, count_d;

    logic signed [2*W-1:0]   mul_a_s, mul_b_s, prod_s;
    logic [W:0]              sat_s;

    // Next-state and datapath logic for the IDLE -> MAC -> OUT sequence.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        acc_d          = acc_q;
        work_v_d       = work_v_q;
        work_c_d       = work_c_q;
        pend_v_d       = pend_v_q;
        pend_full_d    = pend_full_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        overflow_d     = overflow_q;
        dropped_d      = dropped_q;
        count_d        = count_q;

        // Operands sign-extended to 2W so the product keeps full precision.
        mul_a_s = {{W{work_v_q[idx_q][W-1]}}, work_v_q[idx_q]};
        mul_b_s = {{W{work_c_q[idx_q][W-1]}}, work_c_q[idx_q]};
        prod_s  = mul_a_s * mul_b_s;
        sat_s   = shift_sat(acc_q);

        // Starts below read coeff_q, so a same-edge load only affects later starts.
        if (coeff_load) begin
            coeff_d = coeff_in;
        end else begin
            coeff_d = coeff_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (vector_ready) begin
                    work_v_d = vector;
                    work_c_d = coeff_q;
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = ST_MAC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + {{(ACC_W-2*W){prod_s[2*W-1]}}, prod_s};
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = ST_OUT;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                end
                if (vector_ready) begin
                    if (pend_full_q) begin
                        dropped_d   = 1'b1;
                    end else begin
                        pend_v_d    = vector;
                        pend_full_d = 1'b1;
                    end
                end else begin
                    pend_full_d = pend_full_q;
                end
            end
            ST_OUT: begin
                result_d       = sat_s[W-1:0];
                result_valid_d = 1'b1;
                count_d        = count_q + COUNT_ONE;
                if (sat_s[W]) begin
                    overflow_d = 1'b1;
                end else begin
                    overflow_d = overflow_q;
                end
                acc_d = '0;
                idx_d = '0;
                if (pend_full_q) begin
                    // The buffered vector goes first; a simultaneous arrival refills the buffer.
                    work_v_d = pend_v_q;
                    work_c_d = coeff_q;
                    state_d  = ST_MAC;
                    if (vector_ready) begin
                        pend_v_d    = vector;
                        pend_full_d = 1'b1;
                    end else begin
                        pend_full_d = 1'b0;
                    end
                end else if (vector_ready) begin
                    work_v_d = vector;
                    work_c_d = coeff_q;
                    state_d  = ST_MAC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers; everything holds while enabled is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            acc_q          <= '0;
            pend_full_q    <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            overflow_q     <= 1'b0;
            dropped_q      <= 1'b0;
            count_q        <= '0;
            for (int i = 0; i < D; i++) begin
                work_v_q[i] <= '0;
                work_c_q[i] <= '0;
                pend_v_q[i] <= '0;
                coeff_q[i]  <= '0;
            end
        end else if (enabled) begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            acc_q          <= acc_d;
            pend_full_q    <= pend_full_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            overflow_q     <= overflow_d;
            dropped_q      <= dropped_d;
            count_q        <= count_d;
            for (int i = 0; i < D; i++) begin
                work_v_q[i] <= work_v_d[i];
                work_c_q[i] <= work_c_d[i];
                pend_v_q[i] <= pend_v_d[i];
                coeff_q[i]  <= coeff_d[i];
            end
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign pending_full = pend_full_q;
    assign overflow     = overflow_q;
    assign dropped      = dropped_q;
    assign result_count = count_q;

endmodule

// File: tb/tb_vector_dot_product.sv
// ---------------------------------------------------------------------------
// tb_vector_dot_product
//
// Self-checking bench for vector_dot_product at default parameters. The
// reference model computes the dot product with 64-bit integer arithmetic.
// It then floor-shifts and clamps the sum. Inputs change on the falling edge.
// Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_vector_dot_product;

    localparam int W = 24;
    localparam int D = 3;
    localparam int F = 8;
    localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (W - 1));

    typedef logic signed [W-1:0] elem_t;
    typedef elem_t vec_t [0:D-1];

    logic         clk = 1'b0;
    logic         reset;
    logic         enabled;
    logic         vector_ready;
    logic         coeff_load;
    vec_t         vector;
    vec_t         coeff_in;
    elem_t        result;
    logic         result_valid;
    logic         busy;
    logic         pending_full;
    logic         overflow;
    logic         dropped;
    logic [W-1:0] result_count;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   exp_count = 0;
    logic exp_ovf = 1'b0;
    vec_t coeff_model;

    vector_dot_product #(
        .ELEMENT_WIDTH   (W),
        .FRAC_BITS       (F),
        .VECTOR_DIMENSION(D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enabled     (enabled),
        .vector      (vector),
        .vector_ready(vector_ready),
        .coeff_in    (coeff_in),
        .coeff_load  (coeff_load),
        .result      (result),
        .result_valid(result_valid),
        .busy        (busy),
        .pending_full(pending_full),
        .overflow    (overflow),
        .dropped     (dropped),
        .result_count(result_count)
    );

    always #5 clk = ~clk;

    // Reference: exact sum, floor division by 2^F, clamp to W-bit signed.
    function automatic longint ref_shifted(input vec_t v, input vec_t c);
        longint s;
        s = 0;
        for (int i = 0; i < D; i++) s += longint'(v[i]) * longint'(c[i]);
        return s >>> F;
    endfunction

    function automatic elem_t ref_dot(input vec_t v, input vec_t c);
        longint s;
        s = ref_shifted(v, c);
        if (s > MAXV) return elem_t'(MAXV);
        if (s < MINV) return elem_t'(MINV);
        return elem_t'(s);
    endfunction

    function automatic logic ref_sat(input vec_t v, input vec_t c);
        longint s;
        s = ref_shifted(v, c);
        return (s > MAXV) || (s < MINV);
    endfunction

    function automatic elem_t rnd_elem();
        if ($urandom_range(0, 3) == 0) return elem_t'($urandom);
        return elem_t'(int'($urandom_range(0, 8191)) - 4096);
    endfunction

    task automatic load_coeff(input vec_t c);
        coeff_in   = c;
        coeff_load = 1'b1;
        @(negedge clk);
        coeff_load = 1'b0;
        coeff_model = c;
        for (int i = 0; i < D; i++) coeff_in[i] = rnd_elem();
    endtask

    // Pulse one vector and wait for its result; lat = edges from the sampling edge.
    task automatic run_vector(input vec_t v, output int lat, output elem_t res);
        lat = -1;
        res = '0;
        vector       = v;
        vector_ready = 1'b1;
        @(negedge clk);
        vector_ready = 1'b0;
        for (int i = 0; i < D; i++) vector[i] = rnd_elem();
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (result_valid) begin
                lat = k - 1;
                res = result;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enabled = 1'b1; vector_ready = 1'b0; coeff_load = 1'b0;
        for (int i = 0; i < D; i++) begin vector[i] = '0; coeff_in[i] = '0; coeff_model[i] = '0; end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (result !== elem_t'(0)) begin n_fail++; $display("FAIL reset_result: got %h expected 000000", result); end
        n_cmp++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
        n_cmp++; if ({busy, pending_full, overflow, dropped} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy, pending_full, overflow, dropped}); end
        n_cmp++; if (result_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", result_count); end
    endtask

    task automatic test_basic();
        vec_t c, v; int lat; elem_t res;
        c = '{24'h000100, 24'h000100, 24'h000100};
        v = '{24'h000100, 24'h000200, 24'h000300};
        load_coeff(c);
        run_vector(v, lat, res);
        exp_count++;
        n_cmp++; if (res !== 24'h000600) begin n_fail++; $display("FAIL basic_result: got %h expected 000600", res); end
        n_cmp++; if (lat !== D + 1) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, D + 1); end
        n_cmp++; if (result_count !== exp_count[W-1:0]) begin n_fail++; $display("FAIL basic_count: got %0d expected %0d", result_count, exp_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %b expected 0", overflow); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_sign_floor();
        vec_t tv [3]; vec_t tc [3]; elem_t te [3]; int lat; elem_t res;
        tv[0] = '{24'hFFFF00, 24'h000000, 24'h000000}; tc[0] = '{24'h000180, 24'h000000, 24'h000000}; te[0] = 24'hFFFE80;
        tv[1] = '{24'hFFFFFF, 24'h000000, 24'h000000}; tc[1] = '{24'h000080, 24'h000000, 24'h000000}; te[1] = 24'hFFFFFF;
        tv[2] = '{24'h000001, 24'h000000, 24'h000000}; tc[2] = '{24'h000080, 24'h000000, 24'h000000}; te[2] = 24'h000000;
        for (int t = 0; t < 3; t++) begin
            load_coeff(tc[t]);
            run_vector(tv[t], lat, res);
            exp_count++;
            n_cmp++; if (res !== te[t] || lat !== D + 1) begin
                n_fail++; $display("FAIL sign_floor_%0d: got %h lat %0d expected %h lat %0d", t, res, lat, te[t], D + 1); end
        end
    endtask

    task automatic test_random();
        vec_t c, v; int lat; elem_t res, exp_r;
        for (int n = 0; n < 24; n++) begin
            if (n == 0 || $urandom_range(0, 1) == 1) begin
                for (int i = 0; i < D; i++) c[i] = rnd_elem();
                load_coeff(c);
            end
            for (int i = 0; i < D; i++) v[i] = rnd_elem();
            exp_r = ref_dot(v, coeff_model);
            exp_ovf = exp_ovf | ref_sat(v, coeff_model);
            run_vector(v, lat, res);
            exp_count++;
            n_cmp++; if (res !== exp_r || lat !== D + 1) begin
                n_fail++; $display("FAIL random_%0d: got %h lat %0d expected %h lat %0d", n, res, lat, exp_r, D + 1); end
            n_cmp++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL random_overflow_%0d: got %b expected %b", n, overflow, exp_ovf); end
        end
        n_cmp++; if (result_count !== exp_count[W-1:0]) begin n_fail++; $display("FAIL random_count: got %0d expected %0d", result_count, exp_count); end
    endtask

    task automatic test_saturation();
        vec_t c, v; int lat; elem_t res;
        c = '{24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF};
        v = '{24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF};
        load_coeff(c);
        run_vector(v, lat, res);
        exp_count++;
        n_cmp++; if (res !== 24'h7FFFFF) begin n_fail++; $display("FAIL sat_pos: got %h expected 7fffff", res); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat_overflow: got %b expected 1", overflow); end
        v = '{24'h800000, 24'h800000, 24'h800000};
        run_vector(v, lat, res);
        exp_count++;
        exp_ovf = 1'b1;
        n_cmp++; if (res !== 24'h800000) begin n_fail++; $display("FAIL sat_neg: got %h expected 800000", res); end
    endtask

    task automatic test_back_to_back();
        vec_t c, a, b, cv; int ev_t [$]; elem_t ev_r [$]; logic pend_seen, drop_seen;
        for (int i = 0; i < D; i++) begin c[i] = rnd_elem(); a[i] = rnd_elem(); b[i] = rnd_elem(); cv[i] = rnd_elem(); end
        load_coeff(c);
        pend_seen = 1'b0; drop_seen = 1'b0;
        // dropped is sticky from nothing so far; clear it with a reset first.
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        exp_count = 0; exp_ovf = 1'b0;
        load_coeff(c);
        vector = a; vector_ready = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            if (result_valid) begin ev_t.push_back(t); ev_r.push_back(result); end
            if (t == 1) vector = b;
            else if (t == 2) begin vector = cv; pend_seen = pending_full; end
            else if (t == 3) begin vector_ready = 1'b0; drop_seen = dropped; end
        end
        exp_count += 2;
        n_cmp++; if (pend_seen !== 1'b1) begin n_fail++; $display("FAIL b2b_pending: got %b expected 1", pend_seen); end
        n_cmp++; if (drop_seen !== 1'b1) begin n_fail++; $display("FAIL b2b_dropped: got %b expected 1", drop_seen); end
        n_cmp++; if (ev_t.size() !== 2) begin
            n_fail++; $display("FAIL b2b_results: got %0d results expected 2", ev_t.size());
        end else begin
            n_cmp++; if (ev_t[0] !== D + 2 || ev_t[1] - ev_t[0] !== D + 1) begin
                n_fail++; $display("FAIL b2b_timing: got t=%0d,%0d expected t=%0d,%0d", ev_t[0], ev_t[1], D + 2, 2 * D + 3); end
            n_cmp++; if (ev_r[0] !== ref_dot(a, c)) begin n_fail++; $display("FAIL b2b_a: got %h expected %h", ev_r[0], ref_dot(a, c)); end
            n_cmp++; if (ev_r[1] !== ref_dot(b, c)) begin n_fail++; $display("FAIL b2b_b: got %h expected %h", ev_r[1], ref_dot(b, c)); end
        end
        n_cmp++; if (result_count !== exp_count[W-1:0]) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", result_count, exp_count); end
    endtask

    task automatic test_coeff_snapshot();
        vec_t c1, c2, c3, v1, v2, v3, v4; int lat; elem_t res;
        for (int i = 0; i < D; i++) begin
            c1[i] = rnd_elem(); c2[i] = rnd_elem(); c3[i] = rnd_elem();
            v1[i] = rnd_elem(); v2[i] = rnd_elem(); v3[i] = rnd_elem(); v4[i] = rnd_elem();
        end
        load_coeff(c1);
        // Load new coefficients one cycle after the vector was taken.
        vector = v1; vector_ready = 1'b1;
        @(negedge clk);
        vector_ready = 1'b0; coeff_in = c2; coeff_load = 1'b1;
        @(negedge clk);
        coeff_load = 1'b0;
        res = '0; lat = -1;
        for (int k = 3; k <= 40; k++) begin
            @(negedge clk);
            if (result_valid) begin lat = k - 1; res = result; break; end
        end
        exp_count++;
        n_cmp++; if (res !== ref_dot(v1, c1) || lat !== D + 1) begin
            n_fail++; $display("FAIL coeff_old: got %h lat %0d expected %h lat %0d", res, lat, ref_dot(v1, c1), D + 1); end
        run_vector(v2, lat, res);
        exp_count++;
        n_cmp++; if (res !== ref_dot(v2, c2)) begin n_fail++; $display("FAIL coeff_new: got %h expected %h", res, ref_dot(v2, c2)); end
        // Load on the same edge as the start: the start keeps the old set.
        vector = v3; vector_ready = 1'b1; coeff_in = c3; coeff_load = 1'b1;
        @(negedge clk);
        vector_ready = 1'b0; coeff_load = 1'b0;
        res = '0;
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (result_valid) begin res = result; break; end
        end
        exp_count++;
        n_cmp++; if (res !== ref_dot(v3, c2)) begin n_fail++; $display("FAIL coeff_same_edge: got %h expected %h", res, ref_dot(v3, c2)); end
        run_vector(v4, lat, res);
        exp_count++;
        n_cmp++; if (res !== ref_dot(v4, c3)) begin n_fail++; $display("FAIL coeff_after_same_edge: got %h expected %h", res, ref_dot(v4, c3)); end
    endtask

    task automatic test_enable();
        vec_t c, v; int ev_t [$]; elem_t ev_r [$]; logic busy_seen, pend_seen;
        for (int i = 0; i < D; i++) begin c[i] = rnd_elem(); v[i] = rnd_elem(); end
        load_coeff(c);
        busy_seen = 1'b0; pend_seen = 1'b1;
        vector = v; vector_ready = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            if (result_valid) begin ev_t.push_back(t); ev_r.push_back(result); end
            if (t == 1) begin vector_ready = 1'b0; for (int i = 0; i < D; i++) vector[i] = rnd_elem(); end
            else if (t == 2) enabled = 1'b0;
            else if (t == 4) begin busy_seen = busy; vector_ready = 1'b1; end
            else if (t == 5) vector_ready = 1'b0;
            else if (t == 6) pend_seen = pending_full;
            else if (t == 7) enabled = 1'b1;
        end
        exp_count++;
        n_cmp++; if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL enable_busy_hold: got %b expected 1", busy_seen); end
        n_cmp++; if (pend_seen !== 1'b0) begin n_fail++; $display("FAIL enable_ignores_ready: got %b expected 0", pend_seen); end
        n_cmp++; if (ev_t.size() !== 1) begin
            n_fail++; $display("FAIL enable_results: got %0d results expected 1", ev_t.size());
        end else begin
            n_cmp++; if (ev_t[0] !== D + 2 + 5 || ev_r[0] !== ref_dot(v, c)) begin
                n_fail++; $display("FAIL enable_delayed: got %h at t=%0d expected %h at t=%0d", ev_r[0], ev_t[0], ref_dot(v, c), D + 7); end
        end
    endtask

    task automatic test_reset_mid();
        vec_t c, v; int lat; int n_valid; elem_t res;
        for (int i = 0; i < D; i++) begin c[i] = rnd_elem(); v[i] = rnd_elem(); end
        load_coeff(c);
        vector = v; vector_ready = 1'b1;
        @(negedge clk);
        vector_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if ({result, result_count} !== {(2*W){1'b0}}) begin
            n_fail++; $display("FAIL midreset_values: got result %h count %0d expected 0 0", result, result_count); end
        n_cmp++; if ({result_valid, busy, pending_full, overflow, dropped} !== 5'b00000) begin
            n_fail++; $display("FAIL midreset_flags: got %b expected 00000", {result_valid, busy, pending_full, overflow, dropped}); end
        @(negedge clk);
        reset = 1'b0;
        exp_count = 0; exp_ovf = 1'b0;
        for (int i = 0; i < D; i++) coeff_model[i] = '0;
        n_valid = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (result_valid) n_valid++;
        end
        n_cmp++; if (n_valid !== 0) begin n_fail++; $display("FAIL midreset_no_valid: got %0d pulses expected 0", n_valid); end
        load_coeff(c);
        run_vector(v, lat, res);
        exp_count++;
        n_cmp++; if (res !== ref_dot(v, c) || lat !== D + 1) begin
            n_fail++; $display("FAIL midreset_next: got %h lat %0d expected %h lat %0d", res, lat, ref_dot(v, c), D + 1); end
        n_cmp++; if (result_count !== exp_count[W-1:0]) begin n_fail++; $display("FAIL midreset_count: got %0d expected %0d", result_count, exp_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign_floor();
        test_random();
        test_saturation();
        test_back_to_back();
        test_coeff_snapshot();
        test_enable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
